// File: rtl/freq_count_latch_if.sv
// Purpose: control inputs and latched-result outputs of the frequency-meter count/latch stage.
// Latency: none (wiring only).
// Backpressure: none; results are presented with a one-cycle valid pulse and no ready.
interface freq_count_latch_if #(
  parameter int DIGITS = 4
);
  // Measured signal (asynchronous to clk) and synchronous gate controls.
  logic                  sigIn;
  logic                  enable;
  logic                  clear;
  logic                  latch;
  logic [1:0]            testMode;

  // Latched measurement presented to the display driver.
  logic [4*DIGITS-1:0]   bcdOut;
  logic                  overflowOut;
  logic                  valid;

  // Control stage / display side.
  modport master (
    output sigIn, enable, clear, latch, testMode,
    input  bcdOut, overflowOut, valid
  );

  // Counter / latch block.
  modport slave (
    input  sigIn, enable, clear, latch, testMode,
    output bcdOut, overflowOut, valid
  );
endinterface

// File: rtl/freq_count_latch.sv
// Purpose: gated BCD pulse counter with decade prescaler and capture register (FREQCNT_SATURATE_EN selects saturate-on-overflow).
// Latency: sigIn rise -> count update on 4th clk edge; latch rise -> bcdOut/valid on the sampling edge.
// Backpressure: none; edges outside the gate or in narrow pulses are dropped, valid is a single-cycle pulse.
module freq_count_latch #(
  parameter int DIGITS = 4
) (
  input logic               clk,
  input logic               reset,
  freq_count_latch_if.slave bus
);

  localparam int CW = 4 * DIGITS;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic sigPrev;
  logic edgeFlag;

  // Two-flop synchronizer, then a registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sigPrev  <= 1'b0;
      edgeFlag <= 1'b0;
    end else begin
      sync1    <= bus.sigIn;
      sync2    <= sync1;
      sigPrev  <= sync2;
      edgeFlag <= sync2 & ~sigPrev;
    end
  end

  // ---------------------------------------------------------------------
  // Decade prescaler
  // ---------------------------------------------------------------------
  logic [9:0] psc;
  logic [9:0] pscLimit;
  logic       countEdge;
  logic       tick;

  // Terminal prescaler value (divisor - 1) for the selected range.
  always_comb begin
    pscLimit = 10'd0;
    case (bus.testMode)
      2'd0:    pscLimit = 10'd0;
      2'd1:    pscLimit = 10'd9;
      2'd2:    pscLimit = 10'd99;
      default: pscLimit = 10'd999;
    endcase
  end

  // A ">=" compare lets a range change mid-gate (psc already past the new
  // limit) terminate on the next edge instead of running up to a wrap.
  assign countEdge = edgeFlag & bus.enable;
  assign tick      = countEdge & (psc >= pscLimit);

  // Prescaler state: clear wins over any edge arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      psc <= 10'd0;
    end else if (countEdge) begin
      psc <= tick ? 10'd0 : psc + 10'd1;
    end
  end

  // ---------------------------------------------------------------------
  // BCD counter
  // ---------------------------------------------------------------------
  logic [CW-1:0]   count;
  logic [CW-1:0]   countInc;
  logic [DIGITS:0] carry;
  logic            allNines;
  logic            ovf;

  // Ripple-carry BCD increment; carry out of the top digit means all-9s.
  always_comb begin
    countInc = count;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry[i]) begin
        if (count[4*i +: 4] >= 4'd9) begin
          countInc[4*i +: 4] = 4'd0;
          carry[i+1]         = 1'b1;
        end else begin
          countInc[4*i +: 4] = count[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  assign allNines = carry[DIGITS];

  // Count register and sticky overflow; clear has priority over a tick.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (tick) begin
      if (allNines) begin
        ovf <= 1'b1;
`ifdef FREQCNT_SATURATE_EN
        count <= count;
`else
        count <= countInc;
`endif
      end else begin
        count <= countInc;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Capture register
  // ---------------------------------------------------------------------
  logic          latchPrev;
  logic          latchRise;
  logic [CW-1:0] bcdReg;
  logic          ovfReg;
  logic          validReg;

  // latchPrev resets high so a latch held across reset release is ignored.
  assign latchRise = bus.latch & ~latchPrev;

  // Snapshot the pre-update count/ovf on a latch rise; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      latchPrev <= 1'b1;
      bcdReg    <= '0;
      ovfReg    <= 1'b0;
      validReg  <= 1'b0;
    end else begin
      latchPrev <= bus.latch;
      validReg  <= latchRise;
      if (latchRise) begin
        bcdReg <= count;
        ovfReg <= ovf;
      end
    end
  end

  assign bus.bcdOut      = bcdReg;
  assign bus.overflowOut = ovfReg;
  assign bus.valid       = validReg;

endmodule

// File: tb/tb_freq_count_latch.sv
// Purpose: self-checking bench for freq_count_latch against a pulse-count reference model.
// Latency: inputs driven and outputs sampled on the falling clk edge.
// Backpressure: none; all waits are fixed cycle counts.
module tb_freq_count_latch;

  localparam int DIGITS = 4;
  localparam int CW     = 4 * DIGITS;

  logic clk;
  logic reset;

  int nChecks;
  int nPass;

  freq_count_latch_if #(.DIGITS(DIGITS)) bus ();

  freq_count_latch #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendPulses(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      bus.sigIn = 1'b1;
      waitCycles(hi);
      bus.sigIn = 1'b0;
      waitCycles(lo);
    end
  endtask

  task automatic doClear();
    bus.clear = 1'b1;
    waitCycles(1);
    bus.clear = 1'b0;
  endtask

  // Reference: the gate saw `pulses` edges at divisor 10**mode starting from
  // a cleared prescaler, so the count is the whole number of divisor groups.
  function automatic void refModel(input int pulses, input int mode,
                                   output logic [31:0] bcd, output logic ovf);
    int div;
    int span;
    int ticks;
    int value;
    div  = 1;
    for (int i = 0; i < mode; i++) div = div * 10;
    span = 1;
    for (int i = 0; i < DIGITS; i++) span = span * 10;
    ticks = pulses / div;
    ovf   = (ticks >= span);
`ifdef FREQCNT_SATURATE_EN
    value = ovf ? span - 1 : ticks;
`else
    value = ticks % span;
`endif
    bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = 4'(value % 10);
      value = value / 10;
    end
  endfunction

  // Raise latch (optionally with clear) and check the one-cycle result.
  task automatic capture(input string tag, input logic [31:0] expBcd, input logic expOvf,
                         input bit withClear);
    bus.latch = 1'b1;
    bus.clear = withClear;
    waitCycles(1);
    bus.clear = 1'b0;
    checkVal({tag, ".valid"}, 32'(bus.valid), 32'd1);
    checkVal({tag, ".bcd"}, 32'(bus.bcdOut), expBcd);
    checkVal({tag, ".ovf"}, 32'(bus.overflowOut), 32'(expOvf));
    waitCycles(1);
    checkVal({tag, ".validOff"}, 32'(bus.valid), 32'd0);
    bus.latch = 1'b0;
    waitCycles(1);
  endtask

  // One full gate: clear, count, close the gate with settle time, capture.
  task automatic measure(input string tag, input int mode, input int pulses,
                         input int hi, input int lo);
    logic [31:0] expBcd;
    logic        expOvf;
    bus.testMode = 2'(mode);
    doClear();
    bus.enable = 1'b1;
    sendPulses(pulses, hi, lo);
    waitCycles(6);
    bus.enable = 1'b0;
    waitCycles(1);
    refModel(pulses, mode, expBcd, expOvf);
    capture(tag, expBcd, expOvf, 1'b0);
  endtask

  initial begin
    int validSeen;
    nChecks      = 0;
    nPass        = 0;
    reset        = 1'b1;
    bus.sigIn    = 1'b0;
    bus.enable   = 1'b0;
    bus.clear    = 1'b0;
    bus.latch    = 1'b0;
    bus.testMode = 2'd0;
    waitCycles(4);
    reset = 1'b0;
    waitCycles(1);

    checkVal("reset.bcd", 32'(bus.bcdOut), 32'd0);
    checkVal("reset.ovf", 32'(bus.overflowOut), 32'd0);
    checkVal("reset.valid", 32'(bus.valid), 32'd0);

    measure("basic25", 0, 25, 4, 4);
    measure("div10", 1, 125, 2, 2);
    measure("div1000", 3, 2999, 2, 2);

    // Range change mid-gate: 500 edges at /1000 leave psc at 500; at /10 the
    // first edge terminates (500 >= 9), then 10 more edges give a second tick.
    bus.testMode = 2'd3;
    doClear();
    bus.enable = 1'b1;
    sendPulses(500, 2, 2);
    waitCycles(6);
    bus.testMode = 2'd1;
    sendPulses(15, 2, 2);
    waitCycles(6);
    bus.enable = 1'b0;
    capture("modeChange", 32'h0002, 1'b0, 1'b0);

    // Gate closed: edges are ignored and the count holds.
    measure("hold9", 0, 9, 3, 3);
    sendPulses(5, 3, 3);
    waitCycles(6);
    capture("gateOff", 32'h0009, 1'b0, 1'b0);
    doClear();
    waitCycles(2);
    checkVal("clearKeepsOut", 32'(bus.bcdOut), 32'h0009);

    // Clear asserted in the cycle the edge flag is presented to the counter.
    bus.testMode = 2'd0;
    doClear();
    bus.enable = 1'b1;
    bus.sigIn  = 1'b1;
    waitCycles(3);
    bus.clear = 1'b1;
    waitCycles(1);
    bus.clear = 1'b0;
    waitCycles(1);
    bus.sigIn = 1'b0;
    waitCycles(6);
    bus.enable = 1'b0;
    capture("clearPrio", 32'h0000, 1'b0, 1'b0);

    // Clear with a simultaneous latch rise captures the pre-clear count.
    bus.enable = 1'b1;
    sendPulses(7, 2, 2);
    waitCycles(6);
    bus.enable = 1'b0;
    capture("clearCapture", 32'h0007, 1'b0, 1'b1);
    capture("afterClear", 32'h0000, 1'b0, 1'b0);

    // Tick and latch rise on the same edge: pre-increment value is captured.
    doClear();
    bus.enable = 1'b1;
    sendPulses(41, 2, 2);
    waitCycles(6);
    bus.sigIn = 1'b1;
    waitCycles(3);
    bus.latch = 1'b1;
    waitCycles(1);
    checkVal("tickCap.valid", 32'(bus.valid), 32'd1);
    checkVal("tickCap.bcd", 32'(bus.bcdOut), 32'h0041);
    bus.latch = 1'b0;
    waitCycles(1);
    bus.sigIn = 1'b0;
    waitCycles(6);
    bus.enable = 1'b0;
    capture("tickCapNext", 32'h0042, 1'b0, 1'b0);

    // Randomized gates across all ranges and pulse shapes.
    for (int it = 0; it < 8; it++) begin
      measure($sformatf("rand%0d", it), int'($urandom_range(3, 0)),
              int'($urandom_range(400, 0)), int'($urandom_range(4, 2)),
              int'($urandom_range(4, 2)));
    end

    // Overflow past all-9s, then recovery after clear.
    measure("overflow", 0, 10005, 2, 2);
    measure("postOvf", 0, 3, 2, 2);

    // Latch held high across reset release must not capture.
    reset     = 1'b1;
    bus.latch = 1'b1;
    waitCycles(3);
    reset     = 1'b0;
    validSeen = 0;
    for (int k = 0; k < 5; k++) begin
      waitCycles(1);
      if (bus.valid) validSeen++;
    end
    checkVal("latchHeld.noValid", 32'(validSeen), 32'd0);
    checkVal("latchHeld.bcd", 32'(bus.bcdOut), 32'd0);
    bus.latch = 1'b0;
    waitCycles(1);
    capture("postReset", 32'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
